// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB subsystem
package apb_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_SLV_WORDS = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Value of PADDR[7] that selects each slave
    localparam logic SLV1_SEL = 1'b0;
    localparam logic SLV2_SEL = 1'b1;

    // Only the low 256-byte window is populated; anything above it is invalid
    function automatic logic addr_in_window(input logic [DEF_ADDR_W-1:0] addr);
        return (addr[DEF_ADDR_W-1:8] == '0);
    endfunction

endpackage

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB slave RAM; APB_WAIT_STATE_EN adds one wait state per access
module apb_slave
    import apb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_SLV_WORDS,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] mem_d [WORDS];
    logic              wr_en;

`ifdef APB_WAIT_STATE_EN
    // Set after the first ACCESS cycle so PREADY rises on the second one
    logic waited_q;
    logic waited_d;

    always_comb begin
        waited_d = psel & penable & ~waited_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waited_q <= 1'b0;
        end else begin
            waited_q <= waited_d;
        end
    end

    assign pready = waited_q;
`else
    assign pready = 1'b1;
`endif

    assign pslverr = 1'b0;
    assign prdata  = mem_q[idx];
    assign wr_en   = psel & penable & pwrite & pready;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[idx] = pwdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/apb_subsystem.sv
// rtl/apb_subsystem.sv - request front-end, APB master FSM, decoder and two slave RAMs
// APB_WAIT_STATE_EN: slaves insert one wait state; the invalid-address responder stays zero-wait.
module apb_subsystem
    import apb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SLV_WORDS = DEF_SLV_WORDS
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              TRANSFER,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] apb_write_address,
    input  logic [DATA_W-1:0] apb_write_data,
    input  logic [ADDR_W-1:0] apb_read_address,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] apb_read_out
);

    localparam int IDX_W = $clog2(SLV_WORDS);

    apb_state_e        state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] read_out_q, read_out_d;

    logic              psel;
    logic              penable;
    logic              req;
    logic              capture;

    logic              addr_valid;
    logic              sel1, sel2;
    logic [DATA_W-1:0] prdata1, prdata2, bus_prdata;
    logic              pready1, pready2, bus_pready;
    logic              pslverr1, pslverr2, bus_pslverr;

    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign req     = TRANSFER & (read | write);

    assign addr_valid = (paddr_q[ADDR_W-1:8] == '0);
    assign sel1       = psel & addr_valid & (paddr_q[7] == SLV1_SEL);
    assign sel2       = psel & addr_valid & (paddr_q[7] == SLV2_SEL);

    // With no slave selected the default responder completes at once with an error
    always_comb begin
        bus_pready  = 1'b1;
        bus_pslverr = 1'b1;
        bus_prdata  = '0;
        if (sel1) begin
            bus_pready  = pready1;
            bus_pslverr = pslverr1;
            bus_prdata  = prdata1;
        end else if (sel2) begin
            bus_pready  = pready2;
            bus_pslverr = pslverr2;
            bus_prdata  = prdata2;
        end
    end

    always_comb begin
        state_d    = state_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pslverr_d  = pslverr_q;
        read_out_d = read_out_q;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    capture = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus_pready) begin
                    pslverr_d = bus_pslverr;
                    if (!pwrite_q) begin
                        read_out_d = bus_prdata;
                    end
                    if (req) begin
                        state_d = SETUP;
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Write wins when both qualifiers are high
        if (capture) begin
            pwrite_d = write;
            paddr_d  = write ? apb_write_address : apb_read_address;
            pwdata_d = apb_write_data;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pslverr_q  <= 1'b0;
            read_out_q <= '0;
        end else begin
            state_q    <= state_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pslverr_q  <= pslverr_d;
            read_out_q <= read_out_d;
        end
    end

    assign PSLVERR      = pslverr_q;
    assign apb_read_out = read_out_q;

    apb_slave #(
        .DATA_W (DATA_W),
        .WORDS  (SLV_WORDS),
        .IDX_W  (IDX_W)
    ) u_slave1 (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .psel    (sel1),
        .penable (penable),
        .pwrite  (pwrite_q),
        .idx     (paddr_q[IDX_W-1:0]),
        .pwdata  (pwdata_q),
        .prdata  (prdata1),
        .pready  (pready1),
        .pslverr (pslverr1)
    );

    apb_slave #(
        .DATA_W (DATA_W),
        .WORDS  (SLV_WORDS),
        .IDX_W  (IDX_W)
    ) u_slave2 (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .psel    (sel2),
        .penable (penable),
        .pwrite  (pwrite_q),
        .idx     (paddr_q[IDX_W-1:0]),
        .pwdata  (pwdata_q),
        .prdata  (prdata2),
        .pready  (pready2),
        .pslverr (pslverr2)
    );

endmodule

// File: tb/tb_apb_subsystem.sv
// tb/tb_apb_subsystem.sv - self-checking bench for apb_subsystem with a flat 256-word memory model
module tb_apb_subsystem;

`ifdef APB_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        TRANSFER = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] apb_write_address = '0;
    logic [31:0] apb_write_data = '0;
    logic [31:0] apb_read_address = '0;
    logic        PSLVERR;
    logic [31:0] apb_read_out;

    int total = 0;
    int bad = 0;

    logic [31:0] mem_m [256];
    logic        exp_err;
    logic [31:0] exp_rd;

    apb_subsystem dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .TRANSFER          (TRANSFER),
        .read              (read),
        .write             (write),
        .apb_write_address (apb_write_address),
        .apb_write_data    (apb_write_data),
        .apb_read_address  (apb_read_address),
        .PSLVERR           (PSLVERR),
        .apb_read_out      (apb_read_out)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        exp_err = 1'b0;
        exp_rd  = '0;
    endtask

    task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        logic valid;
        valid = (addr < 32'd256);
        exp_err = ~valid;
        if (wr) begin
            if (valid) mem_m[addr[7:0]] = data;
        end else begin
            exp_rd = valid ? mem_m[addr[7:0]] : 32'd0;
        end
    endtask

    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
        logic [31:0] addr;
        int lat;
        addr = wr ? wa : ra;
        lat  = ((addr < 32'd256) && (WS != 0)) ? 3 : 2;
        @(negedge PCLK);
        TRANSFER = 1'b1; read = rd; write = wr;
        apb_write_address = wa; apb_write_data = wd; apb_read_address = ra;
        @(posedge PCLK);
        @(negedge PCLK);
        TRANSFER = 1'b0; read = 1'b0; write = 1'b0;
        apb_write_address = $urandom; apb_write_data = $urandom; apb_read_address = $urandom;
        repeat (lat - 2) @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        chk({tag, "_pre_err"}, {31'd0, PSLVERR}, {31'd0, exp_err});
        chk({tag, "_pre_rd"}, apb_read_out, exp_rd);
        model_apply(wr, addr, wd);
        @(posedge PCLK);
        @(negedge PCLK);
        chk({tag, "_err"}, {31'd0, PSLVERR}, {31'd0, exp_err});
        chk({tag, "_rd"}, apb_read_out, exp_rd);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] a, d, r;
        int k, mode, lat;

        model_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_err", {31'd0, PSLVERR}, 32'd0);
        chk("rst_rd", apb_read_out, 32'd0);
        chk("rst_psel", {31'd0, dut.psel}, 32'd0);
        PRESETn = 1'b1;

        xfer("wr005", 1'b0, 1'b1, 32'h005, 32'hAA, 32'h0);
        xfer("rd005", 1'b1, 1'b0, 32'h0, 32'h0, 32'h005);

        xfer("wr005b", 1'b0, 1'b1, 32'h005, 32'hA5, 32'h0);
        xfer("wr085", 1'b0, 1'b1, 32'h085, 32'h5A, 32'h0);
        xfer("rd005b", 1'b1, 1'b0, 32'h0, 32'h0, 32'h005);
        xfer("rd085", 1'b1, 1'b0, 32'h0, 32'h0, 32'h085);

        xfer("wr1ff", 1'b0, 1'b1, 32'h1FF, 32'hFF, 32'h0);
        xfer("rd07f", 1'b1, 1'b0, 32'h0, 32'h0, 32'h07F);
        xfer("rd0ff", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0FF);
        xfer("rd_bad", 1'b1, 1'b0, 32'h0, 32'h0, 32'h8000_0005);
        xfer("rd085c", 1'b1, 1'b0, 32'h0, 32'h0, 32'h085);

        // Request qualifiers without TRANSFER, and TRANSFER without qualifiers, start nothing
        @(negedge PCLK);
        TRANSFER = 1'b1; read = 1'b0; write = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            chk("idle_xfer_only", {31'd0, dut.psel}, 32'd0);
        end
        TRANSFER = 1'b0; read = 1'b1; write = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            chk("idle_no_xfer", {31'd0, dut.psel}, 32'd0);
        end
        read = 1'b0; write = 1'b0;
        chk("idle_hold_rd", apb_read_out, exp_rd);

        // Back-to-back writes with TRANSFER held; PSEL never drops between them
        lat = 2 + WS;
        @(negedge PCLK);
        TRANSFER = 1'b1; write = 1'b1;
        apb_write_address = 32'h001; apb_write_data = 32'h11;
        @(posedge PCLK);
        for (int j = 1; j <= 3 * lat; j++) begin
            @(negedge PCLK);
            chk("b2b_psel", {31'd0, dut.psel}, 32'd1);
            if (j == 1) begin
                apb_write_address = 32'h002; apb_write_data = 32'h22;
            end else if (j == lat + 1) begin
                apb_write_address = 32'h003; apb_write_data = 32'h33;
            end else if (j == 2 * lat + 1) begin
                TRANSFER = 1'b0; write = 1'b0;
            end
            @(posedge PCLK);
        end
        @(negedge PCLK);
        chk("b2b_done_psel", {31'd0, dut.psel}, 32'd0);
        model_apply(1'b1, 32'h001, 32'h11);
        model_apply(1'b1, 32'h002, 32'h22);
        model_apply(1'b1, 32'h003, 32'h33);
        chk("b2b_err", {31'd0, PSLVERR}, {31'd0, exp_err});
        xfer("b2b_rd1", 1'b1, 1'b0, 32'h0, 32'h0, 32'h001);
        xfer("b2b_rd2", 1'b1, 1'b0, 32'h0, 32'h0, 32'h002);
        xfer("b2b_rd3", 1'b1, 1'b0, 32'h0, 32'h0, 32'h003);

        // Randomised mix over a small address pool spanning both slaves and invalid space
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 9);
            if (k < 8) a = ((k & 4) != 0 ? 32'd128 : 32'd0) + 32'(k & 3);
            else if (k == 8) a = 32'h100 + 32'($urandom_range(0, 255));
            else a = $urandom | 32'h0001_0000;
            k = $urandom_range(0, 9);
            if (k < 8) r = ((k & 4) != 0 ? 32'd128 : 32'd0) + 32'(k & 3);
            else r = 32'h100 + 32'($urandom_range(0, 3));
            d = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0: xfer("rnd_rd", 1'b1, 1'b0, a, d, r);
                1: xfer("rnd_wr", 1'b0, 1'b1, a, d, r);
                2: xfer("rnd_both", 1'b1, 1'b1, a, d, r);
                default: xfer("rnd_wr2", 1'b0, 1'b1, a, d, r);
            endcase
        end

        // Reset asserted during ACCESS of a write aborts it
        xfer("pre_abort", 1'b1, 1'b0, 32'h0, 32'h0, 32'h001);
        @(negedge PCLK);
        TRANSFER = 1'b1; write = 1'b1;
        apb_write_address = 32'h010; apb_write_data = 32'hBB;
        @(posedge PCLK);
        @(negedge PCLK);
        TRANSFER = 1'b0; write = 1'b0;
        @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("abort_psel", {31'd0, dut.psel}, 32'd0);
        chk("abort_err", {31'd0, PSLVERR}, 32'd0);
        chk("abort_rd", apb_read_out, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        model_reset();
        xfer("abort_rd010", 1'b1, 1'b0, 32'h0, 32'h0, 32'h010);
        xfer("abort_rd001", 1'b1, 1'b0, 32'h0, 32'h0, 32'h001);

        do_reset();
        chk("final_rst_rd", apb_read_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
